button_event_arbiter: RTL

- Turns NUM_BTN debounced push-button levels into discrete user commands: SHORT press, LONG press and, optionally, auto-REPEAT.
- Events from all buttons are queued one-deep per button and granted round-robin onto a single valid/ready event port.
- Sits downstream of the per-button debouncers and feeds the mic-filter configuration logic (channel select, gain step, etc.).
- Runs on the 100 MHz system clock.

---
 rtl/btn_evt_pkg.sv | 11 +
 rtl/btn_press_fsm.sv | 68 ++++++
 rtl/button_event_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: shared event-type and per-button FSM state encodings for button_event_arbiter
package btn_evt_pkg;
  localparam logic [1:0] EVT_SHORT  = 2'b00;
  localparam logic [1:0] EVT_LONG   = 2'b01;
  localparam logic [1:0] EVT_REPEAT = 2'b10;
  typedef enum logic [1:0] {ARM, IDLE, PRESS, HELD} btn_state_e;
  // Index of the k-th slot scanned when the round-robin search starts at base.
  function automatic int rr_idx(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction
endpackage

// File: rtl/btn_press_fsm.sv
// btn_press_fsm: classifies one debounced button into SHORT / LONG / REPEAT events
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   btn_i             debounced button level, 1 = pressed
//   evt_raise_o       one-cycle pulse: an event is raised at the coming clock edge
//   evt_kind_o        event type accompanying evt_raise_o
// Build option: BTN_AUTO_REPEAT_EN adds the repeat counter and REPEAT events.
module btn_press_fsm
  import btn_evt_pkg::*;
#(
  parameter int LONG_TICKS = 50_000_000
`ifdef BTN_AUTO_REPEAT_EN
  , parameter int REPEAT_TICKS = 10_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  output logic       evt_raise_o,
  output logic [1:0] evt_kind_o
);
  localparam int HW = $clog2(LONG_TICKS + 1);
  btn_state_e state_q;
  logic [HW-1:0] hold_q;
  logic long_hit;
  // The raise is decoded from the current state so the pending slot captures it on the same edge the FSM moves.
  assign long_hit = state_q == PRESS && btn_i && hold_q == HW'(LONG_TICKS - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS);
  logic [RW-1:0] rep_q;
  logic rep_hit;
  assign rep_hit     = state_q == HELD && btn_i && rep_q == RW'(REPEAT_TICKS - 1);
  assign evt_raise_o = (state_q == PRESS && !btn_i) || long_hit || rep_hit;
  assign evt_kind_o  = long_hit ? EVT_LONG : rep_hit ? EVT_REPEAT : EVT_SHORT;
`else
  assign evt_raise_o = (state_q == PRESS && !btn_i) || long_hit;
  assign evt_kind_o  = long_hit ? EVT_LONG : EVT_SHORT;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARM;
      hold_q  <= '0;
`ifdef BTN_AUTO_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      case (state_q)
        ARM:   if (!btn_i) state_q <= IDLE;
        IDLE:  if (btn_i) begin
          state_q <= PRESS;
          hold_q  <= HW'(1);
        end
        // Release is tested first, so a release on the threshold cycle is a SHORT.
        PRESS: if (!btn_i) state_q <= IDLE;
          else if (long_hit) begin
            state_q <= HELD;
`ifdef BTN_AUTO_REPEAT_EN
            rep_q   <= '0;
`endif
          end else hold_q <= hold_q + 1'b1;
        HELD:  if (!btn_i) state_q <= IDLE;
`ifdef BTN_AUTO_REPEAT_EN
          else rep_q <= rep_hit ? '0 : rep_q + 1'b1;
`endif
      endcase
    end
  end
endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: turns debounced buttons into SHORT/LONG/REPEAT events on one valid/ready port
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   btn_in            debounced button levels, 1 = pressed
//   evt_valid         event available
//   evt_ready         consumer accepts when evt_valid && evt_ready
//   evt_btn           index of the button that produced the event
//   evt_type          00 SHORT, 01 LONG, 10 REPEAT
//   evt_overrun       sticky: a pending event was overwritten before being granted
// Build option: BTN_AUTO_REPEAT_EN enables REPEAT events while a button is held after LONG.
module button_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTN      = 4,
  parameter int LONG_TICKS   = 50_000_000,
  parameter int REPEAT_TICKS = 10_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_in,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_BTN)-1:0] evt_btn,
  output logic [1:0]                 evt_type,
  output logic                       evt_overrun
);
  localparam int BW = $clog2(NUM_BTN);
  logic [NUM_BTN-1:0] evt_raise;
  logic [NUM_BTN-1:0][1:0] evt_kind;
  logic [NUM_BTN-1:0] pend_q, pend_d, clr;
  logic [NUM_BTN-1:0][1:0] ptype_q, ptype_d;
  logic [BW-1:0] ptr_q, ptr_d, btn_q, btn_d, gidx;
  logic [1:0] type_q, type_d;
  logic valid_q, valid_d, ovr_q, ovr_d, gnt_ok, load;
  if (NUM_BTN < 2 || LONG_TICKS < 2 || REPEAT_TICKS < 2) begin : g_bad_params
    $error("button_event_arbiter: NUM_BTN, LONG_TICKS and REPEAT_TICKS must be >= 2");
  end
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_press_fsm #(
      .LONG_TICKS(LONG_TICKS)
`ifdef BTN_AUTO_REPEAT_EN
      , .REPEAT_TICKS(REPEAT_TICKS)
`endif
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .btn_i      (btn_in[i]),
      .evt_raise_o(evt_raise[i]),
      .evt_kind_o (evt_kind[i])
    );
  end
  always_comb begin
    gnt_ok = 1'b0;
    gidx   = '0;
    // Scan from the far end back towards ptr so the nearest set slot wins.
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      if (pend_q[rr_idx(int'(ptr_q), k, NUM_BTN)]) begin
        gnt_ok = 1'b1;
        gidx   = BW'(rr_idx(int'(ptr_q), k, NUM_BTN));
      end
    end
    load    = gnt_ok && (!valid_q || evt_ready);
    clr     = load ? NUM_BTN'(1) << gidx : '0;
    // A slot granted this edge is free again, so a new event for it is not an overrun.
    pend_d  = (pend_q & ~clr) | evt_raise;
    ovr_d   = ovr_q | (|(pend_q & ~clr & evt_raise));
    for (int i = 0; i < NUM_BTN; i++) ptype_d[i] = evt_raise[i] ? evt_kind[i] : ptype_q[i];
    valid_d = load || (valid_q && !evt_ready);
    btn_d   = load ? gidx : btn_q;
    type_d  = load ? ptype_q[gidx] : type_q;
    ptr_d   = !load ? ptr_q : gidx == BW'(NUM_BTN - 1) ? '0 : gidx + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      ptype_q <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      btn_q   <= '0;
      type_q  <= EVT_SHORT;
      ovr_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      ptype_q <= ptype_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      btn_q   <= btn_d;
      type_q  <= type_d;
      ovr_q   <= ovr_d;
    end
  end
  assign evt_valid   = valid_q;
  assign evt_btn     = btn_q;
  assign evt_type    = type_q;
  assign evt_overrun = ovr_q;
endmodule
